// File: rtl/cavlc_coeff_token_enc.sv
// CAVLC coeff_token encoder (0<=nC<2 column): maps (TotalCoeff, TrailingOnes)
// to its codeword and packs codewords MSB-first into 16-bit words with a flush path.
module cavlc_coeff_token_enc (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        InValid,
  output logic        InReady,
  input  logic [4:0]  TotalCoeff,
  input  logic [1:0]  TrailingOnes,
  input  logic        Flush,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [15:0] OutWord,
  output logic [4:0]  OutBits,
  output logic        OutLast,
  output logic        FlushDone,
  output logic        Err
);

  typedef enum logic {ST_PACK, ST_FLUSH} state_t;

  state_t      state, state_nx;
  logic [31:0] acc, acc_nx;
  logic [5:0]  fill, fill_nx;
  logic        fdone_nx, err_nx;

  logic [20:0] lc;
  logic [4:0]  len;
  logic [15:0] code;
  logic        legal;
  logic        accept;
  logic [5:0]  shamt;
  logic [31:0] code32;

  // Codeword table: {length, right-aligned code}
  always_comb begin
    legal = (TotalCoeff <= 5'd16) && ({3'b000, TrailingOnes} <= TotalCoeff);
    lc    = {5'd1, 16'd1};
    case ({TotalCoeff, TrailingOnes})
      {5'd0,  2'd0}: lc = {5'd1,  16'd1};
      {5'd1,  2'd0}: lc = {5'd6,  16'd5};
      {5'd1,  2'd1}: lc = {5'd2,  16'd1};
      {5'd2,  2'd0}: lc = {5'd8,  16'd7};
      {5'd2,  2'd1}: lc = {5'd6,  16'd4};
      {5'd2,  2'd2}: lc = {5'd3,  16'd1};
      {5'd3,  2'd0}: lc = {5'd9,  16'd7};
      {5'd3,  2'd1}: lc = {5'd8,  16'd6};
      {5'd3,  2'd2}: lc = {5'd7,  16'd5};
      {5'd3,  2'd3}: lc = {5'd5,  16'd3};
      {5'd4,  2'd0}: lc = {5'd10, 16'd7};
      {5'd4,  2'd1}: lc = {5'd9,  16'd6};
      {5'd4,  2'd2}: lc = {5'd8,  16'd5};
      {5'd4,  2'd3}: lc = {5'd6,  16'd3};
      {5'd5,  2'd0}: lc = {5'd11, 16'd7};
      {5'd5,  2'd1}: lc = {5'd10, 16'd6};
      {5'd5,  2'd2}: lc = {5'd9,  16'd5};
      {5'd5,  2'd3}: lc = {5'd7,  16'd4};
      {5'd6,  2'd0}: lc = {5'd13, 16'd15};
      {5'd6,  2'd1}: lc = {5'd11, 16'd6};
      {5'd6,  2'd2}: lc = {5'd10, 16'd5};
      {5'd6,  2'd3}: lc = {5'd8,  16'd4};
      {5'd7,  2'd0}: lc = {5'd13, 16'd11};
      {5'd7,  2'd1}: lc = {5'd13, 16'd14};
      {5'd7,  2'd2}: lc = {5'd11, 16'd5};
      {5'd7,  2'd3}: lc = {5'd9,  16'd4};
      {5'd8,  2'd0}: lc = {5'd13, 16'd8};
      {5'd8,  2'd1}: lc = {5'd13, 16'd10};
      {5'd8,  2'd2}: lc = {5'd13, 16'd13};
      {5'd8,  2'd3}: lc = {5'd10, 16'd4};
      {5'd9,  2'd0}: lc = {5'd14, 16'd15};
      {5'd9,  2'd1}: lc = {5'd14, 16'd14};
      {5'd9,  2'd2}: lc = {5'd13, 16'd9};
      {5'd9,  2'd3}: lc = {5'd11, 16'd4};
      {5'd10, 2'd0}: lc = {5'd14, 16'd11};
      {5'd10, 2'd1}: lc = {5'd14, 16'd10};
      {5'd10, 2'd2}: lc = {5'd14, 16'd13};
      {5'd10, 2'd3}: lc = {5'd13, 16'd12};
      {5'd11, 2'd0}: lc = {5'd15, 16'd15};
      {5'd11, 2'd1}: lc = {5'd15, 16'd14};
      {5'd11, 2'd2}: lc = {5'd14, 16'd9};
      {5'd11, 2'd3}: lc = {5'd14, 16'd12};
      {5'd12, 2'd0}: lc = {5'd15, 16'd11};
      {5'd12, 2'd1}: lc = {5'd15, 16'd10};
      {5'd12, 2'd2}: lc = {5'd15, 16'd13};
      {5'd12, 2'd3}: lc = {5'd14, 16'd8};
      {5'd13, 2'd0}: lc = {5'd16, 16'd15};
      {5'd13, 2'd1}: lc = {5'd15, 16'd1};
      {5'd13, 2'd2}: lc = {5'd15, 16'd9};
      {5'd13, 2'd3}: lc = {5'd15, 16'd12};
      {5'd14, 2'd0}: lc = {5'd16, 16'd11};
      {5'd14, 2'd1}: lc = {5'd16, 16'd14};
      {5'd14, 2'd2}: lc = {5'd16, 16'd13};
      {5'd14, 2'd3}: lc = {5'd15, 16'd8};
      {5'd15, 2'd0}: lc = {5'd16, 16'd7};
      {5'd15, 2'd1}: lc = {5'd16, 16'd10};
      {5'd15, 2'd2}: lc = {5'd16, 16'd9};
      {5'd15, 2'd3}: lc = {5'd16, 16'd12};
      {5'd16, 2'd0}: lc = {5'd16, 16'd4};
      {5'd16, 2'd1}: lc = {5'd16, 16'd6};
      {5'd16, 2'd2}: lc = {5'd16, 16'd5};
      {5'd16, 2'd3}: lc = {5'd16, 16'd8};
      default:       lc = {5'd1,  16'd1};
    endcase
  end

  assign len    = lc[20:16];
  assign code   = lc[15:0];
  assign code32 = {16'h0000, code};
  // Fill < 16 whenever a token is accepted, so the shift is always 1..31
  assign shamt  = 6'd32 - fill - {1'b0, len};

  always_comb begin
    InReady  = !Rst && (state == ST_PACK) && (fill < 6'd16);
    OutValid = (state == ST_FLUSH) || (fill >= 6'd16);
    OutWord  = acc[31:16];
    OutLast  = (state == ST_FLUSH);
    OutBits  = '0;
    if (fill >= 6'd16)
      OutBits = 5'd16;
    else if (state == ST_FLUSH)
      OutBits = fill[4:0];
  end

  assign accept = InValid && InReady;

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    fill_nx  = fill;
    fdone_nx = 1'b0;
    err_nx   = 1'b0;
    case (state)
      ST_PACK: begin
        if (fill >= 6'd16) begin
          if (OutReady) begin
            acc_nx  = {acc[15:0], 16'h0000};
            fill_nx = fill - 6'd16;
          end
        end else if (accept) begin
          if (legal) begin
            acc_nx  = acc | (code32 << shamt);
            fill_nx = fill + {1'b0, len};
          end else begin
            err_nx = 1'b1;
          end
        end else if (Flush) begin
          if (fill == 6'd0)
            fdone_nx = 1'b1;
          else
            state_nx = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (OutReady) begin
          acc_nx   = '0;
          fill_nx  = '0;
          fdone_nx = 1'b1;
          state_nx = ST_PACK;
        end
      end
      default: state_nx = ST_PACK;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= ST_PACK;
      acc       <= '0;
      fill      <= '0;
      FlushDone <= 1'b0;
      Err       <= 1'b0;
    end else begin
      state     <= state_nx;
      acc       <= acc_nx;
      fill      <= fill_nx;
      FlushDone <= fdone_nx;
      Err       <= err_nx;
    end
  end

endmodule

// File: tb/tb_cavlc_coeff_token_enc.sv
// Scoreboard bench for cavlc_coeff_token_enc: directed tokens, expected words queued,
// a forked monitor pops and compares on every output handshake.
module tb_cavlc_coeff_token_enc;

  logic        Clk = 1'b0;
  logic        Rst, InValid, Flush, OutReady;
  logic [4:0]  TotalCoeff;
  logic [1:0]  TrailingOnes;
  logic        InReady, OutValid, OutLast, FlushDone, Err;
  logic [15:0] OutWord;
  logic [4:0]  OutBits;

  cavlc_coeff_token_enc dut (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady),
    .TotalCoeff(TotalCoeff), .TrailingOnes(TrailingOnes), .Flush(Flush),
    .OutValid(OutValid), .OutReady(OutReady), .OutWord(OutWord),
    .OutBits(OutBits), .OutLast(OutLast), .FlushDone(FlushDone), .Err(Err)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [15:0] w;
    logic [4:0]  b;
    logic        l;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int fd_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic expect_word(input logic [15:0] w, input logic [4:0] b, input logic l);
    exp_t e;
    e.w = w; e.b = b; e.l = l;
    sb.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic send(input int tc, input int t1);
    bit done;
    done = 1'b0;
    TotalCoeff   = tc[4:0];
    TrailingOnes = t1[1:0];
    InValid      = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge Clk);
      done = InReady;
      @(posedge Clk);
      #1;
    end
    InValid = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_n(input int n, input int tc, input int t1);
    for (int i = 0; i < n; i++) send(tc, t1);
  endtask

  task automatic do_flush();
    bit done;
    done  = 1'b0;
    Flush = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge Clk);
      #1;
      done = FlushDone;
    end
    Flush = 1'b0;
    if (!done) chk("flush_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int fd0, e0;
    Rst = 1'b1; InValid = 1'b0; Flush = 1'b0; OutReady = 1'b1;
    TotalCoeff = '0; TrailingOnes = '0;

    fork
      forever begin
        exp_t e;
        @(negedge Clk);
        if (!Rst) begin
          if (FlushDone) fd_cnt++;
          if (Err) err_cnt++;
          if (OutValid && OutReady) begin
            if (sb.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected_word: got %h/%0d, no word expected", OutWord, OutBits);
            end else begin
              e = sb.pop_front();
              chk("out_word", {16'h0, OutWord}, {16'h0, e.w});
              chk("out_bits", {27'h0, OutBits}, {27'h0, e.b});
              chk("out_last", {31'h0, OutLast}, {31'h0, e.l});
            end
          end
        end
      end
    join_none

    // reset state
    #1 chk("inready_in_reset", {31'h0, InReady}, 32'd0);
    cycles(2);
    chk("rst_outvalid", {31'h0, OutValid}, 32'd0);
    chk("rst_outword", {16'h0, OutWord}, 32'd0);
    chk("rst_outbits", {27'h0, OutBits}, 32'd0);
    chk("rst_outlast", {31'h0, OutLast}, 32'd0);
    chk("rst_flushdone", {31'h0, FlushDone}, 32'd0);
    chk("rst_err", {31'h0, Err}, 32'd0);
    Rst = 1'b0;
    #1 chk("inready_after_rst", {31'h0, InReady}, 32'd1);

    // 16 x "1" -> 0xFFFF the cycle after the 16th accept
    expect_word(16'hFFFF, 5'd16, 1'b0);
    send_n(16, 0, 0);
    chk("full_outvalid", {31'h0, OutValid}, 32'd1);
    chk("full_inready", {31'h0, InReady}, 32'd0);
    cycles(1);
    chk("drained_inready", {31'h0, InReady}, 32'd1);
    chk("drained_outvalid", {31'h0, OutValid}, 32'd0);

    // mixed tokens -> 0x48C5
    expect_word(16'h48C5, 5'd16, 1'b0);
    send(1, 1); send(2, 2); send(3, 3); send(1, 0);
    cycles(2);
    chk("mix_sb_empty", sb.size(), 32'd0);

    // partial word flush
    expect_word(16'h01C0, 5'd10, 1'b1);
    send(4, 0);
    fd0 = fd_cnt;
    do_flush();
    cycles(1);
    chk("flush_done_cnt", fd_cnt - fd0, 32'd1);
    chk("flush_sb_empty", sb.size(), 32'd0);

    // empty flush: pulse only, no word
    fd0 = fd_cnt;
    do_flush();
    cycles(1);
    chk("empty_flush_cnt", fd_cnt - fd0, 32'd1);
    chk("empty_flush_outvalid", {31'h0, OutValid}, 32'd0);

    // backpressure
    OutReady = 1'b0;
    expect_word(16'h5555, 5'd16, 1'b0);
    send_n(8, 1, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("bp_outvalid", {31'h0, OutValid}, 32'd1);
      chk("bp_outword", {16'h0, OutWord}, 32'h5555);
      chk("bp_inready", {31'h0, InReady}, 32'd0);
    end
    @(posedge Clk); #1;
    OutReady = 1'b1;
    cycles(1);
    chk("bp_release_inready", {31'h0, InReady}, 32'd1);
    chk("bp_release_outvalid", {31'h0, OutValid}, 32'd0);
    chk("bp_sb_empty", sb.size(), 32'd0);

    // illegal token dropped
    expect_word(16'hFFFF, 5'd16, 1'b0);
    e0 = err_cnt;
    send_n(8, 0, 0);
    send(1, 2);
    send_n(8, 0, 0);
    cycles(2);
    chk("illegal_err_cnt", err_cnt - e0, 32'd1);
    chk("illegal_sb_empty", sb.size(), 32'd0);

    // straddle: Fill 15 + Len 16 -> 31
    expect_word(16'hFFFE, 5'd16, 1'b0);
    expect_word(16'h0008, 5'd15, 1'b1);
    send_n(15, 0, 0);
    send(16, 0);
    chk("straddle_outvalid", {31'h0, OutValid}, 32'd1);
    cycles(1);
    do_flush();
    cycles(1);
    chk("straddle_sb_empty", sb.size(), 32'd0);

    // reset with Fill 9 remaining and a word pending
    OutReady = 1'b0;
    send_n(15, 0, 0);
    send(4, 0);
    chk("pending_outvalid", {31'h0, OutValid}, 32'd1);
    Rst = 1'b1;
    #1 chk("midrst_inready", {31'h0, InReady}, 32'd0);
    cycles(1);
    chk("midrst_outvalid", {31'h0, OutValid}, 32'd0);
    chk("midrst_outword", {16'h0, OutWord}, 32'd0);
    chk("midrst_outbits", {27'h0, OutBits}, 32'd0);
    chk("midrst_outlast", {31'h0, OutLast}, 32'd0);
    Rst = 1'b0;
    OutReady = 1'b1;
    expect_word(16'hFFFF, 5'd16, 1'b0);
    send_n(16, 0, 0);
    cycles(2);
    fd0 = fd_cnt;
    do_flush();
    cycles(1);
    chk("post_rst_empty_flush", fd_cnt - fd0, 32'd1);
    chk("post_rst_sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
